// File: rtl/ram_bist_pkg.sv
// Shared definitions for the March C- RAM BIST: state encoding and the per-element
// direction/operation table.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_M4   = 3'd5,
        ST_M5   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    typedef struct packed {
        logic down;       // address sweep 15 -> 0
        logic has_read;
        logic read_one;   // expected word is ~PATTERN
        logic has_write;
        logic write_one;  // written word is ~PATTERN
    } elem_t;

    function automatic elem_t elem_info(input state_t st);
        elem_t e;
        e = '0;
        case (st)
            ST_M0: e = '{down: 1'b0, has_read: 1'b0, read_one: 1'b0, has_write: 1'b1, write_one: 1'b0};
            ST_M1: e = '{down: 1'b0, has_read: 1'b1, read_one: 1'b0, has_write: 1'b1, write_one: 1'b1};
            ST_M2: e = '{down: 1'b0, has_read: 1'b1, read_one: 1'b1, has_write: 1'b1, write_one: 1'b0};
            ST_M3: e = '{down: 1'b1, has_read: 1'b1, read_one: 1'b0, has_write: 1'b1, write_one: 1'b1};
            ST_M4: e = '{down: 1'b1, has_read: 1'b1, read_one: 1'b1, has_write: 1'b1, write_one: 1'b0};
            ST_M5: e = '{down: 1'b0, has_read: 1'b1, read_one: 1'b0, has_write: 1'b0, write_one: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic state_t next_element(input state_t st);
        state_t n;
        case (st)
            ST_M0:   n = ST_M1;
            ST_M1:   n = ST_M2;
            ST_M2:   n = ST_M3;
            ST_M3:   n = ST_M4;
            ST_M4:   n = ST_M5;
            ST_M5:   n = ST_DONE;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-data comparator for the RAM BIST: saturating miscompare counter and
// capture of the first failing address/expected/observed words.
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_check,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_expected,
    input  logic [DATA_WIDTH-1:0] i_observed,
    output logic [7:0]            o_fail_count,
    output logic [ADDR_WIDTH-1:0] o_err_address,
    output logic [DATA_WIDTH-1:0] o_err_expected,
    output logic [DATA_WIDTH-1:0] o_err_observed
);

    logic [7:0]            r_fail_count;
    logic [ADDR_WIDTH-1:0] r_err_address;
    logic [DATA_WIDTH-1:0] r_err_expected;
    logic [DATA_WIDTH-1:0] r_err_observed;
    logic                  w_miscompare;

    // Case inequality so that X/Z on the read bus is flagged as a failure.
    assign w_miscompare = i_check && (i_observed !== i_expected);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fail_count   <= 8'h00;
            r_err_address  <= '0;
            r_err_expected <= '0;
            r_err_observed <= '0;
        end else if (i_clear) begin
            r_fail_count   <= 8'h00;
            r_err_address  <= '0;
            r_err_expected <= '0;
            r_err_observed <= '0;
        end else if (w_miscompare) begin
            if (r_fail_count != 8'hFF) begin
                r_fail_count <= r_fail_count + 8'd1;
            end
            if (r_fail_count == 8'h00) begin
                r_err_address  <= i_address;
                r_err_expected <= i_expected;
                r_err_observed <= i_observed;
            end
        end
    end

    assign o_fail_count   = r_fail_count;
    assign o_err_address  = r_err_address;
    assign o_err_expected = r_err_expected;
    assign o_err_observed = r_err_observed;

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST controller for a 16x8 single-port async-read RAM: element FSM,
// address counter and read/write phase bit; read checking lives in ram_bist_checker.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            fail_count,
    output logic [ADDR_WIDTH-1:0] err_address,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic [DATA_WIDTH-1:0] err_observed
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  r_phase;
    logic                  w_phase_nxt;
    elem_t                 w_elem;
    elem_t                 w_elem_nxt;
    logic                  w_busy;
    logic                  w_last_addr;
    logic                  w_addr_done;
    logic                  w_is_read;
    logic                  w_is_write;
    logic                  w_start;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rexp;

    assign w_elem      = elem_info(r_state);
    assign w_elem_nxt  = elem_info(next_element(r_state));
    assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_last_addr = w_elem.down ? (r_addr == '0) : (r_addr == ADDR_MAX);
    assign w_wdata     = w_elem.write_one ? ~PATTERN : PATTERN;
    assign w_rexp      = w_elem.read_one ? ~PATTERN : PATTERN;
    assign w_is_read   = w_busy && w_elem.has_read && !r_phase;
    assign w_is_write  = w_busy && w_elem.has_write && (r_phase || !w_elem.has_read);

    // The read-only element takes one idle cycle after its final read so that
    // done rises with the last compare already folded into fail_count.
    always_comb begin
        w_addr_done = 1'b1;
        if (w_elem.has_read && (w_elem.has_write || w_last_addr)) begin
            w_addr_done = r_phase;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_phase;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_M0;
                    w_addr_nxt  = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            default: begin
                if (!w_addr_done) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (!w_last_addr) begin
                        w_addr_nxt = w_elem.down ? (r_addr - ADDR_WIDTH'(1))
                                                 : (r_addr + ADDR_WIDTH'(1));
                    end else begin
                        w_state_nxt = next_element(r_state);
                        w_addr_nxt  = w_elem_nxt.down ? ADDR_MAX : '0;
                    end
                end
            end
        endcase
    end

    assign ram_write_en = w_is_write;
    assign ram_address  = w_busy ? r_addr : '0;
    assign ram_data_in  = w_is_write ? w_wdata : '0;
    assign busy         = w_busy;
    assign done         = (r_state == ST_DONE);
    assign pass         = done && (fail_count == 8'h00);

    ram_bist_checker #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_checker (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_start),
        .i_check       (w_is_read),
        .i_address     (r_addr),
        .i_expected    (w_rexp),
        .i_observed    (ram_data_out),
        .o_fail_count  (fail_count),
        .o_err_address (err_address),
        .o_err_expected(err_expected),
        .o_err_observed(err_observed)
    );

endmodule
